// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command-driven sequencer feeding an external registered ALU from a 4-entry register file
module alu_seq_ctrl #(
   parameter int ALU_LAT = 1,
   parameter int W       = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_op,
   input  logic [1:0]   cmd_dst,
   input  logic [1:0]   cmd_src_a,
   input  logic [1:0]   cmd_src_b,
   input  logic         cmd_use_imm,
   input  logic [W-1:0] cmd_imm,
   input  logic         ld_en,
   input  logic [1:0]   ld_addr,
   input  logic [W-1:0] ld_data,
   input  logic [1:0]   rd_addr,
   output logic [W-1:0] rd_data,
   output logic         alu_en,
   output logic [2:0]   alu_mode,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_sum,
   input  logic         alu_fz,
   input  logic         alu_fc,
   output logic         done,
   output logic         flag_z,
   output logic         flag_c,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam logic [2:0] LAT = 3'(ALU_LAT);
   state_t       state;
   logic [W-1:0] rf [4];
   logic [2:0]   cnt;
   logic [1:0]   dst;
   logic         wb;
   assign wb        = state == WAIT && cnt == LAT;
   assign cmd_ready = state == IDLE;
   assign busy      = state != IDLE;
   assign rd_data   = rf[rd_addr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         rf       <= '{default: '0};
         cnt      <= '0;
         dst      <= '0;
         done     <= 1'b0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
         alu_en   <= 1'b0;
         alu_mode <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
      end else begin
         done <= wb;
         if (ld_en) rf[ld_addr] <= ld_data;
         if (wb) begin
            rf[dst] <= alu_sum;
            flag_z  <= alu_fz;
            flag_c  <= alu_fc;
         end
         case (state)
            IDLE: if (cmd_valid) begin
               state    <= ISSUE;
               alu_en   <= 1'b1;
               alu_mode <= cmd_op;
               dst      <= cmd_dst;
               alu_a    <= rf[cmd_src_a];
               alu_b    <= cmd_use_imm ? cmd_imm : rf[cmd_src_b];
            end
            ISSUE: begin
               state  <= WAIT;
               alu_en <= 1'b0;
               cnt    <= 3'd1;
            end
            WAIT: if (wb) state <= DONE; else cnt <= cnt + 3'd1;
            default: state <= IDLE;
         endcase
      end
endmodule
